hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage core. Drives the write-enable (xxW) and

---
 rtl/hazard_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage core.
//   Drives the write enables (xxW) and flushes (xxRST) of the IF/ID, ID/EX,
//   EX/MEM and MEM/WB registers plus the PC enable. It handles load-use
//   bubbles, redirect flushes, I/D-memory wait stalls and the HALT drain.
// Ports:
//   CLK, RST               clock; synchronous active-high reset
//   ihit, dhit             imem data valid / dmem access complete
//   memREQ                 instr in MEM accesses dmem
//   idrs, idrt, idusesRT   ID source operands
//   exDRE, exwsel          EX instr is a load / its destination
//   brtaken, exHALT        EX redirect / HALT in EX
//   pcW, ifidW, ifidRST, idexW, idexRST, exmemW, memwbW   pipeline strobes
//   halted                 pipe drained after HALT
//   stallcnt               saturating count of PC-stall cycles in RUN/DWAIT
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DRAIN = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             memREQ,
  input  logic [4:0]       idrs,
  input  logic [4:0]       idrt,
  input  logic             idusesRT,
  input  logic             exDRE,
  input  logic [4:0]       exwsel,
  input  logic             brtaken,
  input  logic             exHALT,
  output logic             pcW,
  output logic             ifidW,
  output logic             ifidRST,
  output logic             idexW,
  output logic             idexRST,
  output logic             exmemW,
  output logic             memwbW,
  output logic             halted,
  output logic [CNT_W-1:0] stallcnt
);

  localparam int unsigned DCW = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

  typedef enum logic [1:0] {S_RUN, S_DWAIT, S_DRAIN, S_HALTED} state_t;

  state_t           state, state_n;
  logic [DCW-1:0]   dcnt, dcnt_n;
  logic [CNT_W-1:0] cnt;
  logic             run_eval;
  logic             dstall;
  logic             loaduse;

  assign dstall  = memREQ & ~dhit;
  assign loaduse = exDRE && (exwsel != 5'd0) &&
                   ((exwsel == idrs) || (idusesRT && (exwsel == idrt)));

  always_comb begin
    pcW      = 1'b0;
    ifidW    = 1'b0;
    ifidRST  = 1'b0;
    idexW    = 1'b0;
    idexRST  = 1'b0;
    exmemW   = 1'b0;
    memwbW   = 1'b0;
    halted   = 1'b0;
    state_n  = state;
    dcnt_n   = dcnt;
    run_eval = 1'b0;

    case (state)
      S_RUN:   run_eval = 1'b1;
      // dhit releases the wait and the cycle is arbitrated like RUN;
      // dstall is necessarily 0 then.
      S_DWAIT: run_eval = dhit;
      S_DRAIN: begin
        ifidRST = 1'b1;
        idexRST = 1'b1;
        if (!dstall) begin
          ifidW  = 1'b1;
          idexW  = 1'b1;
          exmemW = 1'b1;
          memwbW = 1'b1;
          // The count is loaded with DRAIN, so halting on the cycle that
          // consumes the last unit gives exactly DRAIN advancing cycles.
          if (dcnt <= DCW'(1)) state_n = S_HALTED;
          else                 dcnt_n  = dcnt - DCW'(1);
        end
      end
      S_HALTED: halted = 1'b1;
      default:  state_n = S_RUN;
    endcase

    if (run_eval) begin
      state_n = S_RUN;
      if (dstall) begin
        state_n = S_DWAIT;
      end else if (exHALT) begin
        ifidW   = 1'b1;
        ifidRST = 1'b1;
        idexW   = 1'b1;
        idexRST = 1'b1;
        exmemW  = 1'b1;
        memwbW  = 1'b1;
        dcnt_n  = DCW'(DRAIN);
        state_n = S_DRAIN;
      end else if (brtaken) begin
        pcW     = 1'b1;
        ifidW   = 1'b1;
        ifidRST = 1'b1;
        idexW   = 1'b1;
        idexRST = 1'b1;
        exmemW  = 1'b1;
        memwbW  = 1'b1;
      end else if (loaduse) begin
        idexW   = 1'b1;
        idexRST = 1'b1;
        exmemW  = 1'b1;
        memwbW  = 1'b1;
      end else if (!ihit) begin
        ifidW   = 1'b1;
        ifidRST = 1'b1;
        idexW   = 1'b1;
        exmemW  = 1'b1;
        memwbW  = 1'b1;
      end else begin
        pcW     = 1'b1;
        ifidW   = 1'b1;
        idexW   = 1'b1;
        exmemW  = 1'b1;
        memwbW  = 1'b1;
      end
    end

    // Reset forces every strobe low for the whole reset cycle.
    if (RST) begin
      pcW     = 1'b0;
      ifidW   = 1'b0;
      ifidRST = 1'b0;
      idexW   = 1'b0;
      idexRST = 1'b0;
      exmemW  = 1'b0;
      memwbW  = 1'b0;
      halted  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_RUN;
      dcnt  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
      if (((state == S_RUN) || (state == S_DWAIT)) && !pcW && (cnt != '1))
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign stallcnt = RST ? '0 : cnt;

endmodule
